// File: rtl/rs232_packet_tx_pkg.sv
// Shared definitions for the RS232 address/data link: packet FSM encoding
// (identical to the receive side) and the default bit period.
package rs232_packet_tx_pkg;

  localparam int unsigned DEFAULT_BAUD_DIV = 434;
  localparam logic [3:0]  STOP_IDX         = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE            = 2'd0,
    S_SENDING_ADDRESS = 2'd1,
    S_SENDING_DATA    = 2'd2,
    S_DONE            = 2'd3
  } state_t;

endpackage

// File: rtl/rs232_packet_tx_if.sv
// Request/status bundle between a packet source and the RS232 transmitter.
interface rs232_packet_tx_if;
  logic       SEND;
  logic [7:0] ADDR;
  logic [7:0] DATA;
  logic       TX;
  logic       BUSY;
  logic       DONE;

  modport master (output SEND, ADDR, DATA, input  TX, BUSY, DONE);
  modport slave  (input  SEND, ADDR, DATA, output TX, BUSY, DONE);
endinterface

// File: rtl/rs232_packet_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each held
// BAUD_DIV cycles. LOAD is honoured when idle or on the final stop-bit cycle.
module rs232_tx_byte
  import rs232_packet_tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       LOAD,
  input  logic [7:0] BYTE,
  output logic       TX,
  output logic       BYTE_DONE
);

  localparam logic [15:0] LAST_CNT = 16'(BAUD_DIV - 1);

  logic        r_active;
  logic [15:0] r_cnt;
  logic [3:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        w_last;

  assign w_last    = (r_cnt == LAST_CNT);
  assign BYTE_DONE = r_active && w_last && (r_idx == STOP_IDX);
  assign TX        = r_tx;

  // Shifting in ones makes the stop bit fall out of the same shift path.
  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
    end else if (LOAD && (!r_active || BYTE_DONE)) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= BYTE;
      r_tx     <= 1'b0;
    end else if (r_active) begin
      if (w_last) begin
        r_cnt <= '0;
        if (r_idx == STOP_IDX) begin
          r_active <= 1'b0;
          r_idx    <= '0;
          r_tx     <= 1'b1;
        end else begin
          r_idx   <= r_idx + 4'd1;
          r_tx    <= r_shift[0];
          r_shift <= {1'b1, r_shift[7:1]};
        end
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/rs232_packet_tx.sv
// Two-byte packet transmitter: ADDRESS frame then DATA frame back to back,
// followed by a one-cycle DONE pulse.
module rs232_packet_tx
  import rs232_packet_tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic             CLK_50MHZ,
  input  logic             RST,
  rs232_packet_tx_if.slave link
);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_data;
  logic       w_load;
  logic [7:0] w_byte;
  logic       w_byte_done;
  logic       w_tx;

  // The address goes straight into the serializer on acceptance; only DATA
  // needs holding until the address frame completes.
  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && link.SEND)
        r_data <= link.DATA;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_byte    = r_data;
    link.BUSY = 1'b1;
    link.DONE = 1'b0;
    case (r_state)
      S_IDLE: begin
        link.BUSY = 1'b0;
        w_byte    = link.ADDR;
        if (link.SEND) begin
          w_load = 1'b1;
          w_next = S_SENDING_ADDRESS;
        end
      end
      S_SENDING_ADDRESS: begin
        if (w_byte_done) begin
          w_load = 1'b1;
          w_next = S_SENDING_DATA;
        end
      end
      S_SENDING_DATA: begin
        if (w_byte_done)
          w_next = S_DONE;
      end
      S_DONE: begin
        link.DONE = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  rs232_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx_byte (
    .CLK_50MHZ (CLK_50MHZ),
    .RST       (RST),
    .LOAD      (w_load),
    .BYTE      (w_byte),
    .TX        (w_tx),
    .BYTE_DONE (w_byte_done)
  );

  assign link.TX = w_tx;

endmodule

// File: tb/tb_rs232_packet_tx.sv
// Directed bench for rs232_packet_tx with BAUD_DIV=4 (80-cycle packets).
module tb_rs232_packet_tx;

  localparam int unsigned BAUD = 4;
  localparam int          WIN  = 90;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs232_packet_tx_if link();

  rs232_packet_tx #(.BAUD_DIV(BAUD)) dut (
    .CLK_50MHZ (clk),
    .RST       (rst),
    .link      (link)
  );

  int checks = 0;
  int errors = 0;
  logic tx_log   [WIN];
  logic busy_log [WIN];
  logic done_log [WIN];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line order: start, a[0..7], stop, start, d[0..7], stop.
  function automatic logic [19:0] packet_bits(input logic [7:0] a, input logic [7:0] d);
    return {1'b1, d, 1'b0, 1'b1, a, 1'b0};
  endfunction

  // Called just after a negedge; cycle 0 is the interval after the accepting edge.
  task automatic run_packet(input logic [7:0] a, input logic [7:0] d,
                            input int inject_at, input bit hold);
    link.ADDR = a;
    link.DATA = d;
    link.SEND = 1'b1;
    for (int c = 0; c < WIN; c++) begin
      @(negedge clk);
      tx_log[c]   = link.TX;
      busy_log[c] = link.BUSY;
      done_log[c] = link.DONE;
      if (c == 0 && !hold) begin
        link.SEND = 1'b0;
        link.ADDR = ~a;
        link.DATA = ~d;
      end
      if (c == inject_at) begin
        link.SEND = 1'b1;
        link.ADDR = 8'hFF;
        link.DATA = 8'hFF;
      end
      if (c == inject_at + 1) link.SEND = 1'b0;
    end
  endtask

  task automatic check_packet(input string tag, input logic [7:0] a, input logic [7:0] d,
                              input bit tail);
    logic [19:0] bits;
    int dones;
    int bad_tail;
    bits = packet_bits(a, d);
    for (int b = 0; b < 20; b++)
      check($sformatf("%s bit%0d", tag, b),
            32'({tx_log[4*b], tx_log[4*b+1], tx_log[4*b+2], tx_log[4*b+3]}),
            32'({4{bits[b]}}));
    dones = 0;
    for (int c = 0; c < WIN; c++) if (done_log[c]) dones++;
    check({tag, " done_count"}, 32'(dones), 32'd1);
    check({tag, " done@80"}, 32'(done_log[80]), 32'd1);
    check({tag, " busy@0"}, 32'(busy_log[0]), 32'd1);
    check({tag, " busy@80"}, 32'(busy_log[80]), 32'd1);
    check({tag, " tx@80"}, 32'(tx_log[80]), 32'd1);
    check({tag, " busy@81"}, 32'(busy_log[81]), 32'd0);
    if (tail) begin
      bad_tail = 0;
      for (int c = 81; c < WIN; c++) if (tx_log[c] !== 1'b1 || busy_log[c] !== 1'b0) bad_tail++;
      check({tag, " idle_tail"}, 32'(bad_tail), 32'd0);
    end
  endtask

  function automatic logic [7:0] rx_byte(input int base);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = tx_log[base + (i + 1) * 4 + 2];
    return v;
  endfunction

  initial begin
    int cnt;
    rst       = 1'b1;
    link.SEND = 1'b0;
    link.ADDR = 8'h00;
    link.DATA = 8'h00;
    repeat (3) @(negedge clk);
    check("reset tx", 32'(link.TX), 32'd1);
    check("reset busy", 32'(link.BUSY), 32'd0);
    check("reset done", 32'(link.DONE), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1. basic packet, 2. loopback decode
    run_packet(8'hA5, 8'h3C, -10, 1'b0);
    check_packet("basic", 8'hA5, 8'h3C, 1'b1);
    check("loop addr_start", 32'(tx_log[2]), 32'd0);
    check("loop addr_stop", 32'(tx_log[38]), 32'd1);
    check("loop addr", 32'(rx_byte(0)), 32'h0A5);
    check("loop data_start", 32'(tx_log[42]), 32'd0);
    check("loop data_stop", 32'(tx_log[78]), 32'd1);
    check("loop data", 32'(rx_byte(40)), 32'h03C);

    // 3. SEND while busy is ignored
    run_packet(8'hA5, 8'h3C, 30, 1'b0);
    check_packet("busy_send", 8'hA5, 8'h3C, 1'b1);

    // 4. held SEND retriggers 82 cycles later
    run_packet(8'h00, 8'hFF, -10, 1'b1);
    check_packet("held", 8'h00, 8'hFF, 1'b0);
    check("held tx@81", 32'(tx_log[81]), 32'd1);
    check("held restart tx@82", 32'(tx_log[82]), 32'd0);
    check("held busy@82", 32'(busy_log[82]), 32'd1);
    link.SEND = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (link.DONE) cnt++;
    end
    check("held second_done", 32'(cnt), 32'd1);

    // 5. asynchronous reset mid-frame
    link.ADDR = 8'h5A;
    link.DATA = 8'hC3;
    link.SEND = 1'b1;
    @(negedge clk);
    link.SEND = 1'b0;
    repeat (37) @(negedge clk);
    check("midrst busy_before", 32'(link.BUSY), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst tx", 32'(link.TX), 32'd1);
    check("midrst busy", 32'(link.BUSY), 32'd0);
    check("midrst done", 32'(link.DONE), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < WIN; c++) begin
      @(negedge clk);
      if (link.DONE || link.BUSY || !link.TX) cnt++;
    end
    check("midrst quiet", 32'(cnt), 32'd0);
    run_packet(8'hC3, 8'h5A, -10, 1'b0);
    check_packet("after_rst", 8'hC3, 8'h5A, 1'b1);

    // 6. boundary bytes
    run_packet(8'h00, 8'h00, -10, 1'b0);
    check_packet("zeros", 8'h00, 8'h00, 1'b1);
    run_packet(8'hFF, 8'hFF, -10, 1'b0);
    check_packet("ones", 8'hFF, 8'hFF, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
